// File: rtl/poly_interp_pkg.sv
`default_nettype none
// ============================================================================
// poly_interp_pkg : shared types, default sizes and coefficient table
// Rev 1.0
// ============================================================================
package poly_interp_pkg;

  localparam int DATA_W        = 32;
  localparam int DEF_L         = 2;
  localparam int DEF_N_TAPS    = 4;
  localparam int DEF_FRAC_BITS = 26;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Indexed k*L+p: linear interpolation, phase 0 passes x[0], phase 1 averages x[0],x[1]
  localparam logic signed [DATA_W-1:0] COEF [DEF_L*DEF_N_TAPS] = '{
    32'sh0400_0000, 32'sh0200_0000,
    32'sh0000_0000, 32'sh0200_0000,
    32'sh0000_0000, 32'sh0000_0000,
    32'sh0000_0000, 32'sh0000_0000
  };

  function automatic int acc_width(input int n_taps);
    return 64 + $clog2(n_taps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_interpolator_if.sv
`default_nettype none
// ============================================================================
// poly_interpolator_if : valid/ready sample stream
// Rev 1.0
// ============================================================================
interface poly_interpolator_if;
  import poly_interp_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface
`default_nettype wire

// File: rtl/poly_interp_mac.sv
`default_nettype none
// ============================================================================
// poly_interp_mac : one-phase dot product, Q-format rescale, gain and narrow
// Rev 1.0
// ============================================================================
module poly_interp_mac
  import poly_interp_pkg::*;
#(
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int GAIN_SHIFT = 0
) (
  input  logic signed [DATA_W-1:0] x [N_TAPS],
  input  logic signed [DATA_W-1:0] h [N_TAPS],
  output logic        [DATA_W-1:0] y
);

  localparam int c_ACC_W = acc_width(N_TAPS);
  localparam int c_SH_W  = c_ACC_W + GAIN_SHIFT;
  localparam logic signed [c_SH_W-1:0] c_MAX = c_SH_W'(32'sh7FFF_FFFF);
  localparam logic signed [c_SH_W-1:0] c_MIN = c_SH_W'(32'sh8000_0000);
`ifdef POLY_INTERP_SAT_EN
  localparam bit c_SAT = 1'b1;
`else
  localparam bit c_SAT = 1'b0;
`endif

  logic signed [63:0]         w_xk;
  logic signed [63:0]         w_hk;
  logic signed [63:0]         w_prod;
  logic signed [c_ACC_W-1:0]  w_prod_ext;
  logic signed [c_ACC_W-1:0]  w_acc;
  logic signed [c_SH_W-1:0]   w_shifted;
  logic                       w_ovf_hi;
  logic                       w_ovf_lo;

  always_comb begin
    w_xk       = '0;
    w_hk       = '0;
    w_prod     = '0;
    w_prod_ext = '0;
    w_acc      = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_xk       = x[k];
      w_hk       = h[k];
      w_prod     = w_xk * w_hk;
      w_prod_ext = w_prod;
      w_acc      = w_acc + w_prod_ext;
    end
    // Arithmetic shift floors toward -inf; widen before the gain so overflow stays visible
    w_shifted = c_SH_W'(w_acc >>> FRAC_BITS) <<< GAIN_SHIFT;
    w_ovf_hi  = (w_shifted > c_MAX);
    w_ovf_lo  = (w_shifted < c_MIN);
    if (c_SAT && w_ovf_hi)
      y = 32'h7FFF_FFFF;
    else if (c_SAT && w_ovf_lo)
      y = 32'h8000_0000;
    else
      y = w_shifted[DATA_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/poly_interpolator.sv
`default_nettype none
// ============================================================================
// poly_interpolator : polyphase FIR interpolator by L, one output per phase
// Option macro POLY_INTERP_SAT_EN : saturate instead of wrap on narrowing
// Rev 1.0
// ============================================================================
module poly_interpolator
  import poly_interp_pkg::*;
#(
  parameter int L          = DEF_L,
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  poly_interpolator_if.slave  s_axis_data,
  poly_interpolator_if.master m_axis_data
);

  localparam int c_PH_W  = $clog2(L);
  localparam int c_IDX_W = $clog2(L*N_TAPS);
  localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(L-1);

  if ((L*N_TAPS != $size(COEF)) || (L < 2) || (L > 8) || (GAIN_SHIFT < 0) || (GAIN_SHIFT > 3))
  begin : g_bad_cfg
    $error("poly_interpolator: L/N_TAPS/GAIN_SHIFT inconsistent with coefficient table");
  end

  state_t                     r_state;
  logic [c_PH_W-1:0]          r_phase;
  logic signed [DATA_W-1:0]   r_x [N_TAPS];
  logic [DATA_W-1:0]          r_tdata;
  logic                       r_tvalid;
  logic                       r_run;

  logic                       w_last;
  logic                       w_s_tready;
  logic                       w_in_hs;
  logic [c_PH_W-1:0]          w_phase_sel;
  logic [c_IDX_W-1:0]         w_idx;
  logic signed [DATA_W-1:0]   w_x_sel [N_TAPS];
  logic signed [DATA_W-1:0]   w_coef  [N_TAPS];
  logic [DATA_W-1:0]          w_y;

  assign w_last     = (r_state == ST_EMIT) && (r_phase == c_LAST);
  // r_run holds tready low until the first edge after reset release
  assign w_s_tready = r_run && ((r_state == ST_IDLE) || (w_last && m_axis_data.tready));
  assign w_in_hs    = s_axis_data.tvalid && w_s_tready;

  assign s_axis_data.tready = w_s_tready;
  assign m_axis_data.tdata  = r_tdata;
  assign m_axis_data.tvalid = r_tvalid;

  always_comb begin
    if (w_in_hs || (r_phase == c_LAST))
      w_phase_sel = '0;
    else
      w_phase_sel = c_PH_W'(r_phase + 1'b1);

    w_idx = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      // The phase result is computed from the delay line as it will be after the shift
      if (w_in_hs)
        w_x_sel[k] = (k == 0) ? signed'(s_axis_data.tdata) : r_x[k-1];
      else
        w_x_sel[k] = r_x[k];
      w_idx     = c_IDX_W'(k*L + int'(w_phase_sel));
      w_coef[k] = COEF[w_idx];
    end
  end

  poly_interp_mac #(
    .N_TAPS     (N_TAPS),
    .FRAC_BITS  (FRAC_BITS),
    .GAIN_SHIFT (GAIN_SHIFT)
  ) u_mac (
    .x (w_x_sel),
    .h (w_coef),
    .y (w_y)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_run    <= 1'b0;
      for (int k = 0; k < N_TAPS; k++)
        r_x[k] <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_in_hs) begin
        for (int k = 0; k < N_TAPS; k++)
          r_x[k] <= w_x_sel[k];
        r_phase  <= '0;
        r_tdata  <= w_y;
        r_tvalid <= 1'b1;
        r_state  <= ST_EMIT;
      end else if ((r_state == ST_EMIT) && m_axis_data.tready) begin
        if (r_phase == c_LAST) begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
        end else begin
          r_phase <= w_phase_sel;
          r_tdata <= w_y;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_interpolator.sv
`default_nettype none
// ============================================================================
// tb_poly_interpolator : directed self-checking bench for poly_interpolator
// Rev 1.0
// ============================================================================
module tb_poly_interpolator;

  logic aclk = 1'b0;
  logic aresetn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  poly_interpolator_if s_if ();
  poly_interpolator_if m_if ();
  poly_interpolator_if gs_if ();
  poly_interpolator_if gm_if ();

  poly_interpolator #(.GAIN_SHIFT(0)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis_data (s_if),
    .m_axis_data (m_if)
  );

  poly_interpolator #(.GAIN_SHIFT(1)) dut_g (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_axis_data (gs_if),
    .m_axis_data (gm_if)
  );

`ifdef POLY_INTERP_SAT_EN
  localparam logic [31:0] c_GAIN_P0 = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] c_GAIN_P0 = 32'hC000_0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Sample at the falling edge: valid, data and upstream ready together
  task automatic out3(input string tag, input logic v, input logic [31:0] d, input logic sr);
    @(negedge aclk);
    chk({tag, ".tvalid"}, 32'(m_if.tvalid), 32'(v));
    chk({tag, ".tdata"},  m_if.tdata, d);
    chk({tag, ".sready"}, 32'(s_if.tready), 32'(sr));
  endtask

  initial begin
    aresetn      = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    m_if.tready  = 1'b1;
    gs_if.tvalid = 1'b0;
    gs_if.tdata  = '0;
    gm_if.tready = 1'b1;

    // Reset state and delayed tready
    repeat (3) tick();
    out3("reset", 1'b0, 32'h0, 1'b0);
    tick();
    aresetn = 1'b1;
    out3("release", 1'b0, 32'h0, 1'b0);
    tick();
    out3("idle", 1'b0, 32'h0, 1'b1);

    // Basic linear interpolation, 1-cycle latency, then sustained streaming
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h0400_0000;
    tick();
    out3("t1.p0a", 1'b1, 32'h0400_0000, 1'b0);
    s_if.tdata = 32'h0800_0000;
    tick();
    out3("t1.p1a", 1'b1, 32'h0200_0000, 1'b1);
    tick();
    out3("t1.p0b", 1'b1, 32'h0800_0000, 1'b0);
    s_if.tdata = 32'h0C00_0000;
    tick();
    out3("t1.p1b", 1'b1, 32'h0600_0000, 1'b1);
    tick();
    out3("t2.p0c", 1'b1, 32'h0C00_0000, 1'b0);
    s_if.tdata = 32'h1000_0000;
    tick();
    out3("t2.p1c", 1'b1, 32'h0A00_0000, 1'b1);
    tick();
    out3("t2.p0d", 1'b1, 32'h1000_0000, 1'b0);
    s_if.tdata = 32'h0000_0000;
    tick();

    // Stall during phase 1: output held, no input accepted
    m_if.tready = 1'b0;
    out3("t3.stall0", 1'b1, 32'h0E00_0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      out3("t3.stall", 1'b1, 32'h0E00_0000, 1'b0);
    end
    tick();
    m_if.tready = 1'b1;
    out3("t3.resume", 1'b1, 32'h0E00_0000, 1'b1);
    tick();
    out3("t3.p0e", 1'b1, 32'h0000_0000, 1'b0);
    s_if.tvalid = 1'b0;
    tick();
    out3("t3.p1e", 1'b1, 32'h0800_0000, 1'b1);
    tick();
    out3("t3.idle", 1'b0, 32'h0800_0000, 1'b1);

    // Reset mid-burst clears output and delay line
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h1400_0000;
    tick();
    s_if.tvalid = 1'b0;
    out3("t6.p0", 1'b1, 32'h1400_0000, 1'b0);
    tick();
    aresetn = 1'b0;
    #1;
    chk("t6.rst.tvalid", 32'(m_if.tvalid), 32'h0);
    chk("t6.rst.tdata",  m_if.tdata, 32'h0);
    chk("t6.rst.sready", 32'(s_if.tready), 32'h0);
    tick();
    aresetn = 1'b1;
    tick();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h0400_0000;
    tick();
    s_if.tvalid = 1'b0;
    out3("t6.p0", 1'b1, 32'h0400_0000, 1'b0);
    tick();
    out3("t6.p1", 1'b1, 32'h0200_0000, 1'b1);
    tick();

    // Negative sample after reset
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hFC00_0000;
    tick();
    s_if.tvalid = 1'b0;
    out3("t5.p0", 1'b1, 32'hFC00_0000, 1'b0);
    tick();
    out3("t5.p1", 1'b1, 32'hFE00_0000, 1'b1);
    tick();
    out3("t5.idle", 1'b0, 32'hFE00_0000, 1'b1);

    // Gain shift overflow on the GAIN_SHIFT=1 instance
    gs_if.tvalid = 1'b1;
    gs_if.tdata  = 32'h6000_0000;
    tick();
    gs_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("t4.p0.tvalid", 32'(gm_if.tvalid), 32'h1);
    chk("t4.p0.tdata",  gm_if.tdata, c_GAIN_P0);
    tick();
    @(negedge aclk);
    chk("t4.p1.tdata",  gm_if.tdata, 32'h6000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
